// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and parameter defaults for the IF/MEM memory port arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } arb_state_t;

   localparam int AW_DEF           = 32;
   localparam int DW_DEF           = 32;
   localparam int MAX_D_STREAK_DEF = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch port, data port and memory-side bus of the unified-memory arbiter.
interface mem_port_arbiter_if
   import mem_arb_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF
);
   logic          i_req;
   logic [AW-1:0] i_addr;
   logic          i_kill;
   logic [DW-1:0] i_rdata;
   logic          i_valid;
   logic          i_stall;

   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic [DW-1:0] d_rdata;
   logic          d_valid;
   logic          d_stall;

   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_ready;

   // master: the arbiter itself; slave: pipeline stages and memory around it
   modport master (
      input  i_req, i_addr, i_kill, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
      output i_rdata, i_valid, i_stall, d_rdata, d_valid, d_stall,
             mem_req, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      output i_req, i_addr, i_kill, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
      input  i_rdata, i_valid, i_stall, d_rdata, d_valid, d_stall,
             mem_req, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and MEM stage; data has priority,
// a saturating streak counter guarantees fetch progress.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int MAX_D_STREAK = MAX_D_STREAK_DEF,
   parameter int AW           = AW_DEF,
   parameter int DW           = DW_DEF
) (
   input logic                clk,
   input logic                rst,
   mem_port_arbiter_if.master bus
);

   localparam int            SW         = $clog2(MAX_D_STREAK + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

   arb_state_t    state;
   logic [SW-1:0] streak;
   logic          kill_q;
   logic          mem_req_q;
   logic          mem_we_q;
   logic [AW-1:0] mem_addr_q;
   logic [DW-1:0] mem_wdata_q;

   logic          gnt_i;
   logic          gnt_d;
   logic          i_done;
   logic          d_done;

   assign i_done = (state == BUSY_I) && bus.mem_ready;
   assign d_done = (state == BUSY_D) && bus.mem_ready;

   // a kill landing on the completion cycle itself also swallows the fetch
   assign bus.i_valid = i_done && !kill_q && !bus.i_kill;
   assign bus.d_valid = d_done;
   assign bus.i_rdata = bus.i_valid ? bus.mem_rdata : '0;
   assign bus.d_rdata = bus.d_valid ? bus.mem_rdata : '0;
   assign bus.i_stall = bus.i_req && !bus.i_valid;
   assign bus.d_stall = bus.d_req && !bus.d_valid;

   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;

   // On completion only the other port may be granted, giving zero-gap handoff.
   always_comb begin
      gnt_i = 1'b0;
      gnt_d = 1'b0;
      case (state)
         IDLE: begin
            gnt_d = bus.d_req && !(bus.i_req && (streak == STREAK_MAX));
            gnt_i = bus.i_req && !gnt_d;
         end
         BUSY_I:  gnt_d = bus.mem_ready && bus.d_req;
         BUSY_D:  gnt_i = bus.mem_ready && bus.i_req;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         streak      <= '0;
         kill_q      <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         kill_q <= (state == BUSY_I) && !bus.mem_ready && (kill_q || bus.i_kill);

         if (gnt_d) begin
            state       <= BUSY_D;
            mem_req_q   <= 1'b1;
            mem_we_q    <= bus.d_we;
            mem_addr_q  <= bus.d_addr;
            mem_wdata_q <= bus.d_wdata;
            // only data grants that keep a fetch waiting count toward the streak
            if (!bus.i_req)
               streak <= '0;
            else if (streak != STREAK_MAX)
               streak <= streak + 1'b1;
         end else if (gnt_i) begin
            state       <= BUSY_I;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= bus.i_addr;
            mem_wdata_q <= '0;
            streak      <= '0;
         end else if ((state == IDLE) || bus.mem_ready) begin
            state     <= IDLE;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
         end
      end
   end

endmodule
